e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//   Execute-stage multiply/divide unit with architectural HI/LO registers.
//   Handles mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
//   Emits start/busy to the hazard logic, which ORs them into the PC and F/D
//   stall enables so that a later HI/LO instruction cannot issue while an
//   operation is in flight.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1, >=MULT_CYCLES)
// PORTS
//   clk     in   1   clock
//   reset   in   1   synchronous, active-high
//   req     in   1   E-stage instruction valid (0 for bubble/flushed slot)
//   mdu_op  in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//   rs_val  in   32  operand A (forwarded), dividend / mthi/mtlo source
//   rt_val  in   32  operand B (forwarded), divisor
//   start   out  1   combinational: req & op in {1..4} & !busy
//   busy    out  1   registered: operation in flight
//   hi      out  32  HI register
//   lo      out  32  LO register
//   rdata   out  32  combinational: HI if op==7, LO if op==8, else 0
// BEHAVIOUR
//   Reset: reset is synchronous and active-high; clock is clk.
//     On reset, hi=lo=0, busy=0, counter=0 and temp regs=0. Reset overrides
//     everything, including mid-operation; the in-flight result is discarded.
//   Issue: on an edge where start=1:
//     - compute the result into temp_hi/temp_lo;
//     - load cnt with MULT_CYCLES or DIV_CYCLES;
//     - HI/LO are unchanged at this edge.
//   Count: busy = (cnt != 0). While busy, cnt decrements every edge.
//   Retire: on the edge where cnt==1, hi<=temp_hi, lo<=temp_lo and cnt<=0.
//     busy is high for exactly N cycles after the start cycle.
//     New HI/LO values are visible in the first cycle with busy=0.
//   Arithmetic:
//     - mult: {hi,lo} = $signed(A)*$signed(B), 64-bit.
//     - multu: unsigned 64-bit product.
//     - div: lo = quotient truncated toward zero; hi = remainder, which
//       takes the sign of the dividend.
//     - divu: unsigned quotient and remainder.
//     - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//     - Divisor 0 (div/divu): full DIV_CYCLES busy, then hi/lo keep their
//       prior values.
//   mthi/mtlo: when req and !busy, hi (or lo) <= rs_val at the edge. No busy.
//   Ops while busy: any op 1..8 with busy=1 is a protocol violation. Hazard
//     logic stalls it, and the unit ignores it: start=0, no HI/LO write,
//     cnt unaffected. rdata then reflects stale HI/LO and must not be
//     consumed.
//   req=0: no state change regardless of mdu_op. start=0.
//   Op 0 or 9..15: no state change. start=0. rdata=0.
//   Back-to-back: a new mult/div may start in the first cycle busy=0,
//     i.e. the retire-visible cycle. It reads the HI/LO just written only
//     through forwarding, not through this unit.
// TESTING
//   1. Reset, then mult 0xFFFFFFFF*2 (signed), req=1 for one cycle
//      -> start=1 that cycle; busy=1 for 5 cycles; then hi=0xFFFFFFFF,
//      lo=0xFFFFFFFE.
//   2. multu 0xFFFFFFFF*0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE,
//      lo=0x00000001.
//   3. div -7/2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      Then divu 7/0 -> busy 10 cycles; hi/lo unchanged.
//   4. mthi 0x1234 then mflo/mfhi with req=1 -> hi=0x1234 next cycle;
//      rdata=lo / 0x1234; busy stays 0.
//   5. Start div, assert mult and mtlo at busy cycle 3
//      -> start=0, cnt undisturbed, final hi/lo are the div result only.
//   6. Start mult, pulse reset at busy cycle 2
//      -> next cycle busy=0, hi=lo=0; no later retire occurs.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with HI/LO registers and a fixed-latency busy window
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  logic [31:0] hi_q, hi_d, lo_q, lo_d, thi_q, thi_d, tlo_q, tlo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        is_mul, is_div, sgn, a_neg, b_neg, idle_req, retire;
  logic [31:0] ua, ub, uq, ur, quo, rem;
  logic [63:0] prod, res;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = cnt_q != '0;
  always_comb begin
    is_mul   = mdu_op == 4'd1 || mdu_op == 4'd2;
    is_div   = mdu_op == 4'd3 || mdu_op == 4'd4;
    sgn      = mdu_op == 4'd1 || mdu_op == 4'd3;
    start    = req && (is_mul || is_div) && !busy;
    idle_req = req && !busy;
    retire   = cnt_q == CW'(1);
    prod     = sgn ? {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val}
                   : {32'd0, rs_val} * {32'd0, rt_val};
    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing
    a_neg    = sgn && rs_val[31];
    b_neg    = sgn && rt_val[31];
    ua       = a_neg ? -rs_val : rs_val;
    ub       = b_neg ? -rt_val : rt_val;
    uq       = ub == '0 ? '0 : ua / ub;
    ur       = ub == '0 ? '0 : ua % ub;
    quo      = (a_neg ^ b_neg) ? -uq : uq;
    rem      = a_neg ? -ur : ur;
    // A zero divisor retires the current HI/LO, which nothing can change while busy
    res      = is_mul ? prod : rt_val == '0 ? {hi_q, lo_q} : {rem, quo};
    cnt_d    = start ? CW'(is_div ? DIV_CYCLES : MULT_CYCLES) : busy ? cnt_q - 1'b1 : cnt_q;
    thi_d    = start ? res[63:32] : thi_q;
    tlo_d    = start ? res[31:0] : tlo_q;
    hi_d     = retire ? thi_q : idle_req && mdu_op == 4'd5 ? rs_val : hi_q;
    lo_d     = retire ? tlo_q : idle_req && mdu_op == 4'd6 ? rs_val : lo_q;
    rdata    = mdu_op == 4'd7 ? hi_q : mdu_op == 4'd8 ? lo_q : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      thi_q <= '0;
      tlo_q <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      thi_q <= thi_d;
      tlo_q <= tlo_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed self-checking bench for e_mdu; inputs driven and outputs sampled on negedge
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset, req, start, busy;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val, rt_val, hi, lo, rdata;
  int checks = 0;
  int failures = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req), .mdu_op(mdu_op), .rs_val(rs_val),
    .rt_val(rt_val), .start(start), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    #1;
  endtask

  task automatic idle();
    req = 1'b0; mdu_op = 4'd0; rs_val = '0; rt_val = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    @(negedge clk);
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || start !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b hi=%h lo=%h start=%b, need 0/0/0/0", busy, hi, lo, start);
    end
  endtask

  task automatic test_mult();
    int n;
    drive(4'd1, 32'hFFFFFFFF, 32'h2);
    checks++;
    if (start !== 1'b1) begin failures++; $display("FAIL mult_start: start=%b need 1", start); end
    step();
    idle();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL mult_hold: hi=%h lo=%h need 0/0 while busy", hi, lo);
    end
    count_busy(n);
    checks++;
    if (n !== 5) begin failures++; $display("FAIL mult_busy: cycles=%0d need 5", n); end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
      failures++; $display("FAIL mult_result: hi=%h lo=%h need ffffffff/fffffffe", hi, lo);
    end
  endtask

  task automatic test_multu();
    int n;
    drive(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    idle();
    count_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      failures++; $display("FAIL multu: cycles=%0d hi=%h lo=%h need 5 fffffffe/00000001", n, hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    drive(4'd3, 32'hFFFFFFF9, 32'h2);
    step();
    idle();
    count_busy(n);
    checks++;
    if (n !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      failures++; $display("FAIL div_neg: cycles=%0d hi=%h lo=%h need 10 ffffffff/fffffffd", n, hi, lo);
    end
    drive(4'd4, 32'h7, 32'h0);
    step();
    idle();
    count_busy(n);
    checks++;
    if (n !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      failures++; $display("FAIL divu_zero: cycles=%0d hi=%h lo=%h need 10 ffffffff/fffffffd", n, hi, lo);
    end
    drive(4'd3, 32'h80000000, 32'hFFFFFFFF);
    step();
    idle();
    count_busy(n);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin
      failures++; $display("FAIL div_ovf: hi=%h lo=%h need 00000000/80000000", hi, lo);
    end
    drive(4'd3, 32'h7, 32'hFFFFFFFE);
    step();
    idle();
    count_busy(n);
    checks++;
    if (hi !== 32'h1 || lo !== 32'hFFFFFFFD) begin
      failures++; $display("FAIL div_negdivisor: hi=%h lo=%h need 00000001/fffffffd", hi, lo);
    end
    drive(4'd4, 32'hFFFFFFF9, 32'h2);
    step();
    idle();
    count_busy(n);
    checks++;
    if (hi !== 32'h1 || lo !== 32'h7FFFFFFC) begin
      failures++; $display("FAIL divu: hi=%h lo=%h need 00000001/7ffffffc", hi, lo);
    end
  endtask

  task automatic test_move();
    drive(4'd5, 32'h1234, 32'h0);
    checks++;
    if (start !== 1'b0) begin failures++; $display("FAIL mthi_start: start=%b need 0", start); end
    step();
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h7FFFFFFC || busy !== 1'b0) begin
      failures++; $display("FAIL mthi: hi=%h lo=%h busy=%b need 00001234/7ffffffc/0", hi, lo, busy);
    end
    drive(4'd8, 32'h0, 32'h0);
    checks++;
    if (rdata !== 32'h7FFFFFFC) begin failures++; $display("FAIL mflo: rdata=%h need 7ffffffc", rdata); end
    drive(4'd7, 32'h0, 32'h0);
    checks++;
    if (rdata !== 32'h1234) begin failures++; $display("FAIL mfhi: rdata=%h need 00001234", rdata); end
    step();
    drive(4'd6, 32'h5678, 32'h0);
    step();
    checks++;
    if (lo !== 32'h5678 || hi !== 32'h1234 || busy !== 1'b0) begin
      failures++; $display("FAIL mtlo: hi=%h lo=%h busy=%b need 00001234/00005678/0", hi, lo, busy);
    end
    req = 1'b0; mdu_op = 4'd5; rs_val = 32'hAAAA;
    #1;
    checks++;
    if (rdata !== 32'h0 || start !== 1'b0) begin
      failures++; $display("FAIL noreq_comb: rdata=%h start=%b need 0/0", rdata, start);
    end
    step();
    drive(4'd9, 32'hBBBB, 32'h1);
    checks++;
    if (rdata !== 32'h0 || start !== 1'b0) begin
      failures++; $display("FAIL op9_comb: rdata=%h start=%b need 0/0", rdata, start);
    end
    step();
    idle();
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin
      failures++; $display("FAIL ignored_ops: hi=%h lo=%h busy=%b need 00001234/00005678/0", hi, lo, busy);
    end
  endtask

  task automatic test_busy_ops();
    int n;
    drive(4'd3, 32'd100, 32'd7);
    step();
    idle();
    step();
    step();
    drive(4'd1, 32'h3, 32'h3);
    checks++;
    if (start !== 1'b0) begin failures++; $display("FAIL busy_start: start=%b need 0", start); end
    step();
    drive(4'd6, 32'hDEAD, 32'h0);
    step();
    idle();
    count_busy(n);
    checks++;
    if (n !== 6) begin failures++; $display("FAIL busy_cnt: remaining=%0d need 6", n); end
    checks++;
    if (hi !== 32'h2 || lo !== 32'hE) begin
      failures++; $display("FAIL busy_result: hi=%h lo=%h need 00000002/0000000e", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    drive(4'd1, 32'h3, 32'h4);
    step();
    idle();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h need 0/0/0", busy, hi, lo);
    end
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL reset_noretire: busy=%b hi=%h lo=%h need 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    drive(4'd1, 32'd6, 32'd7);
    step();
    idle();
    count_busy(n);
    drive(4'd2, 32'd2, 32'd3);
    checks++;
    if (start !== 1'b1 || hi !== 32'h0 || lo !== 32'd42) begin
      failures++; $display("FAIL b2b_first: start=%b hi=%h lo=%h need 1 00000000/0000002a", start, hi, lo);
    end
    step();
    idle();
    count_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'h0 || lo !== 32'd6) begin
      failures++; $display("FAIL b2b_second: cycles=%0d hi=%h lo=%h need 5 00000000/00000006", n, hi, lo);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_move();
    test_busy_ops();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
